// File: rtl/addsub_limb_seq.sv
// addsub_limb_seq: wide add/subtract sequencer that reuses one W-bit adder
// across the N-bit operands, one limb per cycle, least-significant limb first.
// Valid/ready handshakes on both the operand side and the result side.
module addsub_limb_seq #(
    parameter int N = 256,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int L  = N / W;
    localparam int IW = (L > 1) ? $clog2(L) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          sub_q;
    logic          carry;
    logic [IW-1:0] idx;

    logic [W-1:0]  a_limb;
    logic [W-1:0]  b_limb;
    logic [W-1:0]  s_limb;
    logic          c_limb;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Shared limb adder: subtraction uses a + ~b with the inverted borrow as carry.
    always_comb begin
        a_limb = a_q[idx*W +: W];
        b_limb = b_q[idx*W +: W] ^ {W{sub_q}};
        {c_limb, s_limb} = {1'b0, a_limb} + {1'b0, b_limb} + {{W{1'b0}}, carry};
    end

    // Sequencer: accept operands, walk limbs LSB first, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[idx*W +: W] <= s_limb;
                    carry           <= c_limb;
                    if (idx == LAST_IDX) begin
                        // Final carry of a + ~b + ~bin is the inverted borrow.
                        cout  <= c_limb ^ sub_q;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_limb_seq.sv
// Self-checking bench for addsub_limb_seq: directed table, back-pressure,
// mid-operation reset, and randomized scoreboard runs at W=64, W=256 and W=1.
module tb_addsub_limb_seq;

    localparam int N = 256;
    localparam int W = 64;
    localparam int L = N / W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;

    addsub_limb_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Alternate-width instances: index 0 -> W=256 (L=1), index 1 -> W=1 (L=256)
    logic         alt_in_valid  [2];
    logic         alt_in_ready  [2];
    logic [N-1:0] alt_a         [2];
    logic [N-1:0] alt_b         [2];
    logic         alt_sub       [2];
    logic         alt_cin       [2];
    logic         alt_out_valid [2];
    logic         alt_out_ready [2];
    logic [N-1:0] alt_sum       [2];
    logic         alt_cout      [2];
    logic         alt_busy      [2];

    for (genvar g = 0; g < 2; g++) begin : g_alt
        localparam int AW = (g == 0) ? 256 : 1;
        addsub_limb_seq #(.N(N), .W(AW)) dut_alt (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (alt_in_valid[g]),
            .in_ready  (alt_in_ready[g]),
            .a         (alt_a[g]),
            .b         (alt_b[g]),
            .sub       (alt_sub[g]),
            .cin       (alt_cin[g]),
            .out_valid (alt_out_valid[g]),
            .out_ready (alt_out_ready[g]),
            .sum       (alt_sum[g]),
            .cout      (alt_cout[g]),
            .busy      (alt_busy[g])
        );
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic         cin;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [N:0] sbq[$];     // expected {cout, sum}
    logic [N:0] exp_next;   // expectation for the operand set currently driven

    // Reference model: plain wide arithmetic, borrow taken from the sign bit.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic s, input logic c);
        logic [N:0] r;
        if (s) r = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
        else   r = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
        return r;
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        int unsigned mode;
        mode = $urandom_range(0, 7);
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        if (mode == 0) r = '1;
        if (mode == 1) r = '0;
        return r;
    endfunction

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock on the main DUT with scoreboard push/pop on the handshakes.
    task automatic step();
        logic [N:0] r;
        if (in_valid && in_ready) sbq.push_back(exp_next);
        if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got %h with no operand set pending", {cout, sum});
            end else begin
                r = sbq.pop_front();
                if ({cout, sum} !== r) begin
                    errors++;
                    $display("FAIL sb_result: got %h expected %h", {cout, sum}, r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 400) begin
            step();
            n++;
        end
        if (!out_valid) check(name, 0, 1);
    endtask

    task automatic run_alt(input int k, input int nops, input int bound);
        logic [N:0] q[$];
        logic [N:0] r;
        int n_acc;
        int cyc;
        n_acc = 0;
        cyc   = 0;
        while ((n_acc < nops || q.size() != 0) && cyc < bound) begin
            alt_in_valid[k]  = (n_acc < nops) && ($urandom_range(0, 3) != 0);
            alt_a[k]         = rnd();
            alt_b[k]         = rnd();
            alt_sub[k]       = 1'($urandom_range(0, 1));
            alt_cin[k]       = 1'($urandom_range(0, 1));
            alt_out_ready[k] = 1'($urandom_range(0, 1));
            if (alt_in_valid[k] && alt_in_ready[k]) begin
                q.push_back(model(alt_a[k], alt_b[k], alt_sub[k], alt_cin[k]));
                n_acc++;
            end
            if (alt_out_valid[k] && alt_out_ready[k]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL alt%0d_extra: got %h with no operand set pending", k,
                             {alt_cout[k], alt_sum[k]});
                end else begin
                    r = q.pop_front();
                    if ({alt_cout[k], alt_sum[k]} !== r) begin
                        errors++;
                        $display("FAIL alt%0d_result: got %h expected %h", k,
                                 {alt_cout[k], alt_sum[k]}, r);
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        alt_in_valid[k]  = 1'b0;
        alt_out_ready[k] = 1'b0;
        check($sformatf("alt%0d_accepted", k), n_acc, nops);
        check($sformatf("alt%0d_drained", k), q.size(), 0);
    endtask

    vec_t         tbl[7];
    logic [N-1:0] ones;
    logic [N-1:0] held_s;
    logic         held_c;
    int           lat;
    int           n_acc;
    int           cyc;

    initial begin
        ones = '1;
        tbl[0] = '{a: 1,    b: 1,    sub: 0, cin: 0, exp_sum: 2,        exp_cout: 0};
        tbl[1] = '{a: ones, b: 1,    sub: 0, cin: 0, exp_sum: 0,        exp_cout: 1};
        tbl[2] = '{a: 5,    b: 3,    sub: 1, cin: 1, exp_sum: 1,        exp_cout: 0};
        tbl[3] = '{a: 0,    b: 1,    sub: 1, cin: 0, exp_sum: ones,     exp_cout: 1};
        tbl[4] = '{a: ones, b: 0,    sub: 0, cin: 1, exp_sum: 0,        exp_cout: 1};
        tbl[5] = '{a: 0,    b: 0,    sub: 1, cin: 1, exp_sum: ones,     exp_cout: 1};
        tbl[6] = '{a: 0,    b: 1,    sub: 0, cin: 1, exp_sum: 2,        exp_cout: 0};
        tbl[5].a = {1'b1, 128'd0};
        tbl[5].b = {1'b1, 128'd0};
        tbl[6].a = {1'b1, 64'd0};
        tbl[6].b = 1;
        tbl[6].sub = 1;
        tbl[6].cin = 0;
        tbl[6].exp_sum = {64'hFFFF_FFFF_FFFF_FFFF};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
        exp_next = '0;
        for (int k = 0; k < 2; k++) begin
            alt_in_valid[k] = 1'b0; alt_a[k] = '0; alt_b[k] = '0;
            alt_sub[k] = 1'b0; alt_cin[k] = 1'b0; alt_out_ready[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum_cout", {cout, sum}, 0);
        rst = 1'b0;
        step();

        // Directed vectors with latency and operand-isolation checks
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            a = tbl[i].a; b = tbl[i].b; sub = tbl[i].sub; cin = tbl[i].cin;
            exp_next = {tbl[i].exp_cout, tbl[i].exp_sum};
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            a = rnd(); b = rnd(); sub = ~sub; cin = ~cin;
            check($sformatf("t%0d_busy", i), {in_ready, busy}, 2'b01);
            lat = 0;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check($sformatf("t%0d_latency", i), lat, L);
            check($sformatf("t%0d_result", i), {cout, sum}, {tbl[i].exp_cout, tbl[i].exp_sum});
            step();
            check($sformatf("t%0d_ready_after", i), {in_ready, out_valid}, 2'b10);
        end

        // Back-pressure: result held while out_ready is low, inputs refused
        out_ready = 1'b0;
        a = rnd(); b = rnd(); sub = 1'b0; cin = 1'b1;
        exp_next = model(a, b, sub, cin);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("bp_timeout");
        held_s = sum;
        held_c = cout;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                a = rnd(); b = rnd();
                exp_next = model(a, b, sub, cin);
            end
            step();
            in_valid = 1'b0;
        end
        check("bp_hold", {cout, sum}, {held_c, held_s});
        check("bp_flags", {in_ready, out_valid, busy}, 3'b011);
        out_ready = 1'b1;
        step();
        check("bp_release", {in_ready, out_valid}, 2'b10);
        check("bp_queue_empty", sbq.size(), 0);

        // Reset while RUN is at limb index 2
        a = rnd(); b = rnd(); sub = 1'b1; cin = 1'b0;
        exp_next = model(a, b, sub, cin);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {in_ready, out_valid, busy}, 3'b100);
        check("mid_rst_sum", {cout, sum}, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a = 7; b = 9; sub = 1'b0; cin = 1'b0;
        exp_next = {1'b0, 256'd16};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("post_rst_timeout");
        check("post_rst_result", {cout, sum}, {1'b0, 256'd16});
        step();

        // Random traffic with random consumer stalls
        n_acc = 0;
        cyc = 0;
        while ((n_acc < 1000 || sbq.size() != 0) && cyc < 40000) begin
            in_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            a = rnd(); b = rnd();
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            exp_next = model(a, b, sub, cin);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) n_acc++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_accepted", n_acc, 1000);
        check("rand_drained", sbq.size(), 0);

        run_alt(0, 300, 4000);
        run_alt(1, 15, 6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_limb_seq.md
Name: addsub_limb_seq

Overview:
- Multi-cycle sequencer for wide add/subtract.
- Time-multiplexes one W-bit full-adder chain over the N-bit operands, one limb per cycle, LSB limb first.
- The inter-limb carry/borrow is held in a register.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.
- Trades latency for area against a flat N-bit ripple or look-ahead adder.

Parameters:
- N, 256, total operand width in bits; must be a multiple of W.
- W, 64, limb width per cycle; 1 <= W <= N.
- L (localparam), N/W, limb count and compute latency in cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept an operand set.
- a  input  N  minuend / addend.
- b  input  N  subtrahend / addend.
- sub  input  1  0 = add, 1 = subtract; sampled at accept.
- cin  input  1  carry-in (add) or borrow-in (sub); sampled at accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  N  result, low N bits.
- cout  output  1  carry-out (add) or borrow-out (sub).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: sum = (a - b - cin) mod 2^N; cout = 1 iff a < b + cin (unsigned).
  - sub is implemented as a + ~b + ~cin; stored cout = ~final_carry.
- Reset (any time, including mid-operation), all asynchronous:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - sum = 0; cout = 0; limb index = 0; carry register = 0.
  - Any in-flight operation is discarded and produces no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge E0: latch a, b and sub.
  - carry register <= cin ^ sub.
  - index <= 0; go to RUN.
- RUN:
  - in_ready = 0; in_valid ignored.
  - At each edge, limb i = index: sum[i*W +: W] <= a_i + (b_i ^ {W{sub}}) + carry; carry <= limb carry-out; index <= index + 1.
  - At the edge where index == L-1: cout <= carry_out ^ sub; go to DONE.
- DONE:
  - out_valid = 1; sum and cout stable; in_ready = 0.
  - On out_valid & out_ready at an edge: out_valid <= 0; go to IDLE. The next operand set can be accepted on the following edge.
  - out_ready low holds DONE indefinitely, with no change to sum or cout.
- Latency: the accept edge is E0; out_valid is high after edge E_L (L cycles after accept). Throughput is one operation per L+2 cycles.
- sum is valid only while out_valid = 1; partial limbs are visible during RUN and must not be consumed.
- Operand changes on a/b/sub/cin after accept have no effect.
- L == 1 (W == N): RUN lasts exactly one cycle.
- Index counter width is clog2(L), minimum 1; it never exceeds L-1.

Test Plan:
- Basic add (N=256, W=64): a=1, b=1, sub=0, cin=0 -> out_valid exactly 4 cycles after accept edge; sum=2, cout=0.
- Full ripple: a=2^256-1, b=1, sub=0, cin=0 -> sum=0, cout=1; limb carry propagates through all 4 limbs.
- Subtract:
  - a=5, b=3, sub=1, cin=1 -> sum=1, cout=0.
  - a=0, b=1, sub=1, cin=0 -> sum=2^256-1, cout=1 (borrow).
- Back-pressure:
  - out_ready=0 for 10 cycles after out_valid -> sum/cout unchanged, in_ready=0, a pulsed in_valid is not accepted.
  - out_ready=1 -> in_ready=1 next cycle.
- Reset mid-op: assert rst while RUN is at index 2 -> in_ready=1, out_valid=0, sum=0 immediately. A following op (a=7, b=9, add) returns sum=16, cout=0.
- Random: 1000 random a/b/sub/cin with random out_ready stalls, also run with W=256 and W=1 -> every result matches the reference model; exactly one result per accepted operand set.
